mmul_result_reader: RTL and testbench
=====================================

Name: mmul_result_reader

Overview:
- Reader/initiator on the far side of the mmul result interface.
- Raises enable to the multiplier and waits for done.
- Snapshots the flat result bus, then streams the elements out one per handshake on a valid/ready port, in row-major order with row/col tags.
- Flags invalid results and multiplier timeouts; it is the consumer of the flat-bus/done protocol that the multiplier produces.

Parameters:
- M, 3, result row count
- L, 3, result column count
- WIDTH, 8, element width in bits
- TIMEOUT, 1024, max cycles to wait for done_in after enable_out rises; 0 disables the timeout

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request one read; sampled only in IDLE
- mat_in  in  M*L*WIDTH  flat result bus from multiplier; element (i,j) = mat_in[(i*L+j)*WIDTH +: WIDTH]
- done_in  in  1  multiplier result valid
- invalid_in  in  1  multiplier dimension-mismatch flag, qualified by done_in
- enable_out  out  1  enable to multiplier
- out_data  out  WIDTH  current element
- out_row  out  clog2(M) (min 1)  row of out_data
- out_col  out  clog2(L) (min 1)  column of out_data
- out_valid  out  1  element available
- out_ready  in  1  downstream accepts
- out_last  out  1  high with final element (M-1,L-1)
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on invalid result or timeout

Behaviour:
- Reset (async, immediate): state=IDLE; enable_out, out_valid, out_last, busy, err = 0; out_data, out_row, out_col = 0; snapshot register and counters cleared.
- IDLE: start=1 -> REQ. enable_out rises the cycle after start is sampled. start while busy is ignored; no queuing.
- REQ:
  - enable_out=1, timeout counter increments each cycle.
  - done_in=1 and invalid_in=0 -> capture mat_in into the snapshot register, drop enable_out, go to STREAM with index 0.
  - done_in=1 and invalid_in=1 -> drop enable_out, err=1 for exactly one cycle, go to IDLE; nothing is streamed.
  - Counter reaches TIMEOUT with no done_in -> same path as invalid: err pulse, enable_out=0, IDLE. done_in on the same cycle as the timeout wins; the result is captured.
- STREAM:
  - out_valid=1. out_data/out_row/out_col come from the snapshot at the current index.
  - Index runs row-major 0..M*L-1; row = index / L, col = index % L. Use separate row/col counters; no divider.
  - Handshake = out_valid & out_ready. Index advances only on a handshake.
  - While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold stable.
  - out_last = (row==M-1 && col==L-1).
  - Handshake on the last element -> IDLE, out_valid=0 on the next cycle. No wrap to index 0.
- Changes to mat_in, done_in or invalid_in during STREAM have no effect; the snapshot is isolated.
- done_in outside REQ is ignored.
- Zero-bubble: back-to-back handshakes deliver one element per cycle. Minimum read time, start to last handshake = 2 + done latency + M*L cycles.
- Reset asserted mid-stream or mid-request aborts immediately to IDLE with all outputs at reset values. The partial stream is lost and no err is raised.
- Widths: every element is passed through unmodified at WIDTH bits; no arithmetic on data.

Decomposition:
- Shared package mmul_pkg:
  - state enum (IDLE, REQ, STREAM)
  - clog2-based width helper function for the row/col index widths
  - element-index function (i*L+j)*WIDTH, shared with the multiplier and its bench
- One natural sub-module, mmul_elem_sel: combinational selector returning the WIDTH-bit element for a given row/col from the flat snapshot. Reusable by a future writer-side block.

Test Plan:
- Nominal 3x3, WIDTH 8, mat_in element k = k+1 (k=0..8), done_in 4 cycles after enable_out, out_ready=1 -> 9 consecutive beats with data 1..9, (row,col) (0,0)..(2,2), out_last only on data 9, enable_out low the cycle after done_in, busy drops after beat 9.
- Backpressure: same data, out_ready toggling 1,0,0,1,... -> no duplicated or skipped elements; out_data held while ready=0; total 9 beats.
- Invalid: done_in=1 with invalid_in=1 -> err high exactly 1 cycle, out_valid never asserted, return to IDLE, enable_out=0.
- Timeout: TIMEOUT=16, done_in never asserted -> err pulse on the 16th REQ cycle, enable_out falls, busy=0.
- Snapshot isolation: change mat_in to all 8'hFF after capture -> stream still yields 1..9.
- Mid-stream reset after beat 4, then a new start -> all outputs 0 immediately, no err; the next read streams from (0,0) correctly.

Source files
------------

// File: rtl/mmul_pkg.sv
// Shared types and helpers for the mmul result interface (reader, multiplier and benches).
package mmul_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB position of element (i,j) in a row-major flat bus with l columns.
  function automatic int elem_lsb(input int i, input int j, input int l, input int width);
    return (i * l + j) * width;
  endfunction

endpackage

// File: rtl/mmul_elem_sel.sv
// Combinational selector: picks element (row,col) out of a flat row-major matrix bus.
module mmul_elem_sel
  import mmul_pkg::*;
#(
  parameter int M     = 3,
  parameter int L     = 3,
  parameter int WIDTH = 8,
  localparam int RW   = idx_w(M),
  localparam int CW   = idx_w(L)
) (
  input  logic [M*L*WIDTH-1:0] flat,
  input  logic [RW-1:0]        row,
  input  logic [CW-1:0]        col,
  output logic [WIDTH-1:0]     elem
);

  // Constant-offset mux over all positions; out-of-range row/col yields zero.
  always_comb begin
    elem = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < L; j++) begin
        if (row == RW'(i) && col == CW'(j)) begin
          elem = flat[elem_lsb(i, j, L, WIDTH) +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/mmul_result_reader.sv
// Result reader: enables the multiplier, waits for done, snapshots the flat result
// bus and streams it row-major over valid/ready. err is a registered one-cycle
// pulse in the first IDLE cycle after an invalid result or a timeout; the
// timeout fires after TIMEOUT REQ cycles without done_in (0 disables it).
module mmul_result_reader
  import mmul_pkg::*;
#(
  parameter int M       = 3,
  parameter int L       = 3,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024,
  localparam int RW     = idx_w(M),
  localparam int CW     = idx_w(L)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [M*L*WIDTH-1:0] mat_in,
  input  logic                 done_in,
  input  logic                 invalid_in,
  output logic                 enable_out,
  output logic [WIDTH-1:0]     out_data,
  output logic [RW-1:0]        out_row,
  output logic [CW-1:0]        out_col,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e               state_q, state_d;
  logic [M*L*WIDTH-1:0] snap_q, snap_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 tmo_hit;
  logic                 at_last;
  logic [WIDTH-1:0]     sel_elem;

  // tmo_q counts completed REQ cycles, so the TIMEOUT-th REQ cycle sees TIMEOUT-1.
  assign tmo_hit = (TIMEOUT != 0) && (int'(tmo_q) == TIMEOUT - 1);
  assign at_last = (row_q == RW'(M - 1)) && (col_q == CW'(L - 1));

  mmul_elem_sel #(
    .M     (M),
    .L     (L),
    .WIDTH (WIDTH)
  ) u_sel (
    .flat (snap_q),
    .row  (row_q),
    .col  (col_q),
    .elem (sel_elem)
  );

  // Next-state logic: request, capture/abort, then row-major streaming on handshakes.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    tmo_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        tmo_d = tmo_q + TW'(1);
        if (done_in) begin
          // done_in takes priority over a coincident timeout
          if (invalid_in) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            snap_d  = mat_in;
            row_d   = '0;
            col_d   = '0;
            state_d = STREAM;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (col_q == CW'(L - 1)) begin
            col_d = '0;
            if (row_q == RW'(M - 1)) begin
              row_d   = '0;
              state_d = IDLE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, snapshot and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign enable_out = (state_q == REQ);
  assign out_valid  = (state_q == STREAM);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_last   = out_valid && at_last;
  assign out_data   = out_valid ? sel_elem : '0;

endmodule

// File: tb/tb_mmul_result_reader.sv
// Directed bench for mmul_result_reader (3x3, 8-bit, TIMEOUT=16).
module tb_mmul_result_reader;

  localparam int M   = 3;
  localparam int L   = 3;
  localparam int W   = 8;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [M*L*W-1:0] mat_in;
  logic             done_in;
  logic             invalid_in;
  logic             enable_out;
  logic [W-1:0]     out_data;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             err;

  int total = 0;
  int bad   = 0;

  mmul_result_reader #(
    .M       (M),
    .L       (L),
    .WIDTH   (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mat_in     (mat_in),
    .done_in    (done_in),
    .invalid_in (invalid_in),
    .enable_out (enable_out),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mat_seq();
    for (int k = 0; k < M * L; k++) mat_in[k*W +: W] = 8'(k + 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".busy"},  32'(busy),      32'd0);
    check_eq({tag, ".en"},    32'(enable_out), 32'd0);
    check_eq({tag, ".last"},  32'(out_last),  32'd0);
    check_eq({tag, ".data"},  32'(out_data),  32'd0);
    check_eq({tag, ".row"},   32'(out_row),   32'd0);
    check_eq({tag, ".col"},   32'(out_col),   32'd0);
  endtask

  // Pulse start and confirm enable_out comes up the cycle after.
  task automatic start_read();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("req.en", 32'(enable_out), 32'd1);
    check_eq("req.busy", 32'(busy), 32'd1);
  endtask

  // Raise done_in in the lat-th REQ cycle; enable_out must be low right after.
  task automatic give_done(input int lat, input logic inval);
    repeat (lat - 1) tick();
    check_eq("pre_done.en", 32'(enable_out), 32'd1);
    done_in    = 1'b1;
    invalid_in = inval;
    tick();
    done_in    = 1'b0;
    invalid_in = 1'b0;
    check_eq("post_done.en", 32'(enable_out), 32'd0);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic stream_chk(input int mode, input int stop_after, output int beats);
    int k   = 0;
    int cyc = 0;
    while (k < M * L && k < stop_after && cyc < 200) begin
      out_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      check_eq("beat.valid", 32'(out_valid), 32'd1);
      check_eq("beat.data",  32'(out_data),  32'(k + 1));
      check_eq("beat.row",   32'(out_row),   32'(k / L));
      check_eq("beat.col",   32'(out_col),   32'(k % L));
      check_eq("beat.last",  32'(out_last),  32'(k == M * L - 1));
      tick();
      if (out_ready) k++;
      cyc++;
    end
    out_ready = 1'b1;
    if (cyc >= 200) check_eq("stream.timeout", 32'(cyc), 32'd0);
    beats = k;
  endtask

  int beats;
  int n_en;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    done_in    = 1'b0;
    invalid_in = 1'b0;
    out_ready  = 1'b1;
    mat_in     = '0;
    tick();
    tick();
    check_idle_outputs("rst");
    check_eq("rst.err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    // Nominal read
    set_mat_seq();
    start_read();
    give_done(4, 1'b0);
    stream_chk(0, M * L, beats);
    check_eq("nom.beats", 32'(beats), 32'd9);
    check_idle_outputs("nom.end");
    check_eq("nom.err", 32'(err), 32'd0);
    tick();

    // Backpressure
    start_read();
    give_done(4, 1'b0);
    stream_chk(1, M * L, beats);
    check_eq("bp.beats", 32'(beats), 32'd9);
    check_idle_outputs("bp.end");
    tick();

    // Snapshot isolation: bus and done/invalid change after capture
    start_read();
    give_done(3, 1'b0);
    mat_in     = {(M*L*W){1'b1}};
    done_in    = 1'b1;
    invalid_in = 1'b1;
    stream_chk(0, M * L, beats);
    done_in    = 1'b0;
    invalid_in = 1'b0;
    check_eq("iso.beats", 32'(beats), 32'd9);
    check_eq("iso.err", 32'(err), 32'd0);
    check_idle_outputs("iso.end");
    set_mat_seq();
    tick();

    // Invalid result
    start_read();
    give_done(2, 1'b1);
    check_eq("inv.err", 32'(err), 32'd1);
    check_idle_outputs("inv");
    tick();
    check_eq("inv.err_clr", 32'(err), 32'd0);
    check_eq("inv.valid2", 32'(out_valid), 32'd0);

    // Timeout: enable_out high for exactly TMO cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    n_en = 0;
    for (int c = 0; c < 40; c++) begin
      if (!enable_out) break;
      check_eq("tmo.err_low", 32'(err), 32'd0);
      n_en++;
      tick();
    end
    check_eq("tmo.cycles", 32'(n_en), 32'(TMO));
    check_eq("tmo.err", 32'(err), 32'd1);
    check_idle_outputs("tmo");
    tick();
    check_eq("tmo.err_clr", 32'(err), 32'd0);

    // Mid-stream reset after 4 beats, then a clean read
    start_read();
    give_done(4, 1'b0);
    stream_chk(0, 4, beats);
    check_eq("mrst.beats", 32'(beats), 32'd4);
    reset = 1'b1;
    #1;
    check_idle_outputs("mrst");
    check_eq("mrst.err", 32'(err), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("mrst.err2", 32'(err), 32'd0);
    start_read();
    give_done(4, 1'b0);
    stream_chk(0, M * L, beats);
    check_eq("post.beats", 32'(beats), 32'd9);
    check_idle_outputs("post.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
